// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory-access stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: datapath width defaults, the access FSM state type and the
// mask applied to the byte-offset bits of a data-memory address.
package mem_pkg;

   localparam int XLEN_DEFAULT       = 32;
   localparam int REG_ADDR_W_DEFAULT = 5;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_RSP = 1'b1
   } mem_state_t;

   // Applied to address bits [1:0]; all-zero forces word alignment.
   localparam logic [1:0] WORD_ALIGN_MASK = 2'b00;

endpackage

// File: rtl/mem_wb_pipeline.sv
// mem_wb_pipeline: MEM/WB boundary register for the writeback result.
// Latency: 1 cycle from an enabled capture to the wb_* outputs.
// Backpressure: when en=0 the stage is stalled; a bubble (wb_RW=0) is
//   inserted while wb_result/wb_rd hold their previous values.
// Ports: clk, rst (sync, active-high); en = capture enable; kill = drop
//   the register write of the captured op; result/rd/rw = next values;
//   wb_result/wb_rd/wb_RW = registered outputs.
module mem_wb_pipeline
   import mem_pkg::*;
#(
   parameter int XLEN       = XLEN_DEFAULT,
   parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  kill,
   input  logic [XLEN-1:0]       result,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic                  rw,
   output logic [XLEN-1:0]       wb_result,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  wb_RW
);

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_result <= '0;
         wb_rd     <= '0;
         wb_RW     <= 1'b0;
      end else if (en) begin
         wb_result <= result;
         wb_rd     <= rd;
         // x0 is hardwired to zero, so a write to it is never reported.
         wb_RW     <= rw && (rd != '0) && !kill;
      end else begin
         wb_RW     <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; issues word loads/stores to dmem and
//   registers the writeback result into the MEM/WB boundary.
// Latency: ALU ops 1 cycle; stores 1 cycle + ready wait; loads >= 2 cycles.
// Backpressure: stall_out (combinational) holds EX/MEM and earlier stages
//   while a store waits for ready or a load is outstanding.
// Ports: in_* = EX/MEM register outputs; dmem_req_* valid/ready request;
//   dmem_rsp_* response (valid only); wb_* = MEM/WB register outputs.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
//   (adds misalign_trap/misalign_addr); otherwise addr[1:0] is masked.
module mem_stage
   import mem_pkg::*;
#(
   parameter int XLEN       = XLEN_DEFAULT,
   parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [XLEN-1:0]       in_alu_result,
   input  logic [XLEN-1:0]       in_rs2_val,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic                  in_RW,
   input  logic                  in_MR,
   input  logic                  in_MW,
   output logic                  stall_out,
   output logic                  dmem_req_valid,
   input  logic                  dmem_req_ready,
   output logic                  dmem_req_we,
   output logic [XLEN-1:0]       dmem_req_addr,
   output logic [XLEN-1:0]       dmem_req_wdata,
   input  logic                  dmem_rsp_valid,
   input  logic [XLEN-1:0]       dmem_rsp_rdata,
   output logic [XLEN-1:0]       wb_result,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  wb_RW
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic                  misalign_trap,
   output logic [XLEN-1:0]       misalign_addr
`endif
);

   mem_state_t state;
   logic       mem_op;
   logic       misaligned;
   logic       issue;

   assign mem_op = in_MR | in_MW;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned    = (state == IDLE) && mem_op && (in_alu_result[1:0] != 2'b00);
   assign dmem_req_addr = in_alu_result;
`else
   assign misaligned    = 1'b0;
   assign dmem_req_addr = {in_alu_result[XLEN-1:2], in_alu_result[1:0] & WORD_ALIGN_MASK};
`endif

   // A request is only ever presented from IDLE, so at most one is in flight.
   assign issue          = (state == IDLE) && mem_op && !misaligned;
   assign dmem_req_valid = issue;
   assign dmem_req_we    = in_MW;
   assign dmem_req_wdata = in_rs2_val;

   // Loads always stall in IDLE (data arrives later); stores stall only
   // until accepted. MR+MW together is handled as a load.
   always_comb begin
      stall_out = 1'b0;
      unique case (state)
         IDLE:     if (issue) stall_out = in_MR | !dmem_req_ready;
         WAIT_RSP: stall_out = !dmem_rsp_valid;
         default:  stall_out = 1'b0;
      endcase
   end

   // Responses seen in IDLE are ignored: only WAIT_RSP consumes them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE:     if (issue && in_MR && dmem_req_ready) state <= WAIT_RSP;
            WAIT_RSP: if (dmem_rsp_valid) state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_trap <= 1'b0;
         misalign_addr <= '0;
      end else begin
         misalign_trap <= misaligned;
         if (misaligned) misalign_addr <= in_alu_result;
      end
   end
`endif

   mem_wb_pipeline #(
      .XLEN       (XLEN),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_mem_wb (
      .clk       (clk),
      .rst       (rst),
      .en        (!stall_out),
      .kill      (misaligned),
      .result    (in_MR ? dmem_rsp_rdata : in_alu_result),
      .rd        (in_rd),
      .rw        (in_RW),
      .wb_result (wb_result),
      .wb_rd     (wb_rd),
      .wb_RW     (wb_RW)
   );

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline; consumes EX/MEM pipeline-register outputs.
- Issues word loads/stores to the data-memory port using a valid/ready request and a valid response.
- Stalls upstream while an access is outstanding.
- Registers the writeback result into the MEM/WB boundary.

Parameters:
- XLEN, 32, datapath and address width.
- REG_ADDR_W, 5, destination-register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_alu_result  in  XLEN  ALU result; also the memory address for loads/stores.
- in_rs2_val  in  XLEN  store data.
- in_rd  in  REG_ADDR_W  destination register.
- in_RW  in  1  register-write enable.
- in_MR  in  1  memory read (load).
- in_MW  in  1  memory write (store).
- stall_out  out  1  hold EX/MEM and earlier stages (combinational).
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_req_we  out  1  1 = store.
- dmem_req_addr  out  XLEN  word address.
- dmem_req_wdata  out  XLEN  store data.
- dmem_rsp_valid  in  1  load data valid.
- dmem_rsp_rdata  in  XLEN  load data.
- wb_result  out  XLEN  registered writeback value.
- wb_rd  out  REG_ADDR_W  registered destination.
- wb_RW  out  1  registered write enable.

Behaviour:
- Reset: state=IDLE; wb_result=0, wb_rd=0, wb_RW=0. All combinational outputs derive from state, so dmem_req_valid=0 and stall_out=0 unless an input op is present.
- A bubble is an all-zero input (produced by an upstream flush). It passes through as wb_RW=0.
- FSM states: IDLE, WAIT_RSP. At most one access is outstanding.
- IDLE:
  - dmem_req_valid = in_MR|in_MW.
  - dmem_req_we = in_MW; dmem_req_addr = in_alu_result; dmem_req_wdata = in_rs2_val.
- IDLE, store:
  - ready=1: store completes this cycle; stall_out=0.
  - ready=0: stall_out=1; the request stays asserted with stable fields (inputs are held by the stall).
- IDLE, load:
  - Always stall_out=1.
  - ready=1: go to WAIT_RSP.
- IDLE, in_MR and in_MW both set: treated as a load; both flags stay visible on dmem_req_we (=1). This is an illegal decode, and the bench flags it with an assertion.
- WAIT_RSP:
  - dmem_req_valid=0.
  - rsp_valid=0: stall_out=1.
  - rsp_valid=1: stall_out=0, capture the response, return to IDLE.
- A dmem_rsp_valid arriving in IDLE (e.g. after a reset mid-load) is discarded.
- MEM/WB capture (posedge, when stall_out=0):
  - wb_result = in_MR ? dmem_rsp_rdata : in_alu_result.
  - wb_rd = in_rd.
  - wb_RW = in_RW && (in_rd != 0).
- MEM/WB capture (posedge, when stall_out=1): wb_RW=0 (bubble); wb_result and wb_rd hold.
- Latency:
  - ALU ops: 1 cycle to wb.
  - Stores: 1 cycle plus ready-wait.
  - Loads: ≥2 cycles (request handshake, then response).
- Reset in WAIT_RSP: return to IDLE next edge and clear wb outputs. A late response is ignored.
- dmem_req_addr[1:0] is forced to 00 (word-aligned access) unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Enabled:
  - Adds ports misalign_trap (out, 1) and misalign_addr (out, XLEN), both registered, reset 0.
  - If (in_MR|in_MW) and in_alu_result[1:0]!=0 in IDLE: no request is issued, stall_out=0, wb_RW=0.
  - Next edge: misalign_trap=1 for one cycle and misalign_addr=in_alu_result.
  - dmem_req_addr passes through unmasked.
- Disabled: the ports are absent; the low address bits are masked to 00 and the access proceeds.

Decomposition:
- Package mem_pkg:
  - XLEN and REG_ADDR_W defaults.
  - State enum mem_state_t {IDLE, WAIT_RSP}.
  - Constant WORD_ALIGN_MASK.
- Sub-module mem_wb_pipeline: the MEM/WB register (wb_result/wb_rd/wb_RW), with enable = !stall_out and bubble insertion on stall. The FSM and request logic stay in mem_stage.

Test Plan:
- ALU op, alu_result=0x1234, rd=5, RW=1 → next cycle wb_result=0x1234, wb_rd=5, wb_RW=1; stall_out never high.
- Load, addr=0x100, ready=1, rsp_valid after 3 cycles with 0xDEADBEEF → stall_out high for 4 cycles; one request handshake; wb_result=0xDEADBEEF, wb_RW=1 on the cycle after the response.
- Store, addr=0x200, data=0xCAFE, ready held low for 2 cycles → req_valid/addr/wdata stable for 3 cycles; stall_out high 2 cycles; wb_RW=0 after.
- Load with rd=0 → access performed, wb_RW=0.
- Reset asserted in WAIT_RSP, response arrives 1 cycle later → state IDLE, wb_RW=0, response ignored, no stall.
- MEM_MISALIGN_TRAP_EN on, load addr=0x102 → no dmem_req_valid, misalign_trap pulses 1 cycle with misalign_addr=0x102; with the macro off → request issued with addr=0x100.
